servo_pwm_array: RTL and testbench

Parametrised multi-channel servo PWM generator that accepts signed Q15.16 angles over a valid/ready write port, converts each to a pulse width in clock counts, and drives N PWM outputs. It is the sequential successor of the single-channel combinational angle-to-duty converter. It sits between the motion controller (angle source) and the servo pins. New widths take effect glitch-free at period boundaries, with optional per-period slew limiting.

---
 rtl/servo_pwm_array_pkg.sv | 31 +++
 rtl/servo_pwm_array_if.sv | 22 ++
 rtl/servo_pwm_array_conv.sv | 88 ++++++++
 rtl/servo_pwm_array.sv | 112 +++++++++++
 tb/tb_servo_pwm_array.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/servo_pwm_array_pkg.sv
// servo_pwm_array shared definitions.
// Angle field layout, widths, converter states.
package servo_pwm_array_pkg;

  localparam int SIGN_BIT = 31;
  localparam int DEG_MSB  = 30;
  localparam int FRAC_W   = 16;
  localparam int DUTY_W   = 20;
  localparam int XITA_W   = 32;
  localparam int CH_W     = 4;
  localparam int MAG_W    = 23;
  localparam int K_W      = 10;
  localparam int PROD_W   = MAG_W + K_W;
  localparam int OFF_W    = PROD_W - FRAC_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_STORE = 2'd2
  } conv_st_e;

  // Magnitude clamp to the degree limit.
  function automatic logic [MAG_W-1:0] clamp_mag(
    input logic [DEG_MSB:0] mag,
    input logic [DEG_MSB:0] lim
  );
    if (mag > lim) clamp_mag = lim[MAG_W-1:0];
    else clamp_mag = mag[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/servo_pwm_array_if.sv
// servo_pwm_array angle write port.
// Valid/ready handshake plus error strobe.
interface servo_pwm_array_if;
  import servo_pwm_array_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [XITA_W-1:0] wr_xita;
  logic              wr_err;

  modport master (
    output wr_valid, wr_ch, wr_xita,
    input  wr_ready, wr_err
  );

  modport slave (
    input  wr_valid, wr_ch, wr_xita,
    output wr_ready, wr_err
  );

endinterface

// File: rtl/servo_pwm_array_conv.sv
// servo_pwm_array angle-to-width converter.
// Three-state IDLE/MUL/STORE pipeline, one write per 3 clocks.
module servo_pwm_array_conv
  import servo_pwm_array_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CENTER_CNT = 75000,
  parameter int K_PER_DEG  = 555,
  parameter int MAX_DEG    = 90
) (
  input  logic              clk,
  input  logic              rst,
  servo_pwm_array_if.slave  wr,
  output logic              st_we,
  output logic [CH_W-1:0]   st_ch,
  output logic [DUTY_W-1:0] st_width
);

  localparam int MIN_W = DEG_MSB + 1;
  localparam logic [DEG_MSB:0] LIM =
    MIN_W'(MAX_DEG) << FRAC_W;
  localparam logic [K_W-1:0] KQ = K_W'(K_PER_DEG);
  localparam logic [DUTY_W-1:0] CQ =
    DUTY_W'(CENTER_CNT);

  conv_st_e          st_q;
  conv_st_e          st_d;
  logic              neg_q;
  logic [MAG_W-1:0]  mag_q;
  logic [CH_W-1:0]   ch_q;
  logic [DUTY_W-1:0] w_q;
  logic              err_q;
  logic [PROD_W-1:0] prod;
  logic [OFF_W-1:0]  off;
  logic              ok_ch;
  logic              acc;

  assign acc   = wr.wr_valid && (st_q == ST_IDLE);
  assign prod  = PROD_W'(mag_q) * PROD_W'(KQ);
  assign off   = prod[PROD_W-1:FRAC_W];
  assign ok_ch = {1'b0, ch_q} < (CH_W+1)'(N_CH);

  assign wr.wr_ready = (st_q == ST_IDLE);
  assign wr.wr_err   = err_q;
  assign st_we       = (st_q == ST_STORE) && ok_ch;
  assign st_ch       = ch_q;
  assign st_width    = w_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else st_q <= st_d;
  end

  // Next-state: accept, multiply, store, back to idle.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  if (wr.wr_valid) st_d = ST_MUL;
      ST_MUL:   st_d = ST_STORE;
      ST_STORE: st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  // Capture request, form width, flag bad channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      neg_q <= 1'b0;
      mag_q <= '0;
      w_q   <= CQ;
      err_q <= 1'b0;
    end else begin
      err_q <= (st_q == ST_STORE) && !ok_ch;
      if (acc) begin
        ch_q  <= wr.wr_ch;
        neg_q <= wr.wr_xita[SIGN_BIT];
        mag_q <= clamp_mag(wr.wr_xita[DEG_MSB:0], LIM);
      end
      if (st_q == ST_MUL) begin
        w_q <= neg_q ? CQ - DUTY_W'(off)
                     : CQ + DUTY_W'(off);
      end
    end
  end

endmodule

// File: rtl/servo_pwm_array.sv
// servo_pwm_array: N-channel servo PWM generator.
// Widths switch only at period boundaries, optional slew.
module servo_pwm_array
  import servo_pwm_array_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PERIOD_CNT = 1000000,
  parameter int CENTER_CNT = 75000,
  parameter int K_PER_DEG  = 555,
  parameter int MAX_DEG    = 90,
  parameter int STEP_MAX   = 0
) (
  input  logic            clk,
  input  logic            rst,
  servo_pwm_array_if.slave wr,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] pwm,
  output logic            period_start
);

  localparam int PW = $clog2(PERIOD_CNT);
  localparam int CW = (PW > DUTY_W) ? PW : DUTY_W;
  localparam logic [CW-1:0] LAST = CW'(PERIOD_CNT - 1);
  localparam logic [DUTY_W-1:0] CQ =
    DUTY_W'(CENTER_CNT);
  localparam logic [DUTY_W-1:0] STEP =
    DUTY_W'(STEP_MAX);

  logic [CW-1:0]     cnt;
  logic              wrap;
  logic [DUTY_W-1:0] shadow [N_CH];
  logic [DUTY_W-1:0] active [N_CH];
  logic [DUTY_W-1:0] nxt    [N_CH];
  logic [N_CH-1:0]   pend;
  logic              st_we;
  logic [CH_W-1:0]   st_ch;
  logic [DUTY_W-1:0] st_width;

  servo_pwm_array_conv #(
    .N_CH       (N_CH),
    .CENTER_CNT (CENTER_CNT),
    .K_PER_DEG  (K_PER_DEG),
    .MAX_DEG    (MAX_DEG)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .st_we    (st_we),
    .st_ch    (st_ch),
    .st_width (st_width)
  );

  assign wrap = (cnt == LAST);

  // Free-running period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else cnt <= wrap ? '0 : cnt + CW'(1);
  end

  // Boundary target: jump, or step toward shadow.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      nxt[i] = active[i];
      if (STEP_MAX == 0) begin
        nxt[i] = shadow[i];
      end else if (shadow[i] > active[i]) begin
        nxt[i] = (shadow[i] - active[i] > STEP)
               ? active[i] + STEP : shadow[i];
      end else begin
        nxt[i] = (active[i] - shadow[i] > STEP)
               ? active[i] - STEP : shadow[i];
      end
    end
  end

  // Shadow writes and boundary promotion; store wins pend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= CQ;
        active[i] <= CQ;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wrap && pend[i]) begin
          active[i] <= nxt[i];
          if (nxt[i] == shadow[i]) pend[i] <= 1'b0;
        end
        if (st_we && st_ch == CH_W'(i)) begin
          shadow[i] <= st_width;
          pend[i]   <= 1'b1;
        end
      end
    end
  end

  // Registered compare and period marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= (cnt == '0);
      for (int i = 0; i < N_CH; i++) begin
        pwm[i] <= en[i] && (cnt < CW'(active[i]));
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// tb_servo_pwm_array: scaled-period bench, two slew settings.
// Pulse widths per period checked against a spec-level model.
module tb_servo_pwm_array;

  localparam int P  = 400;
  localparam int C  = 200;
  localparam int K  = 2;
  localparam int MD = 90;
  localparam int S1 = 40;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NC-1:0] en;
  logic [NC-1:0] pwm0, pwm1;
  logic ps0, ps1;

  servo_pwm_array_if if0 ();
  servo_pwm_array_if if1 ();

  servo_pwm_array #(
    .N_CH(NC), .PERIOD_CNT(P), .CENTER_CNT(C),
    .K_PER_DEG(K), .MAX_DEG(MD), .STEP_MAX(0)
  ) dut0 (
    .clk(clk), .rst(rst), .wr(if0), .en(en),
    .pwm(pwm0), .period_start(ps0)
  );

  servo_pwm_array #(
    .N_CH(NC), .PERIOD_CNT(P), .CENTER_CNT(C),
    .K_PER_DEG(K), .MAX_DEG(MD), .STEP_MAX(S1)
  ) dut1 (
    .clk(clk), .rst(rst), .wr(if1), .en(en),
    .pwm(pwm1), .period_start(ps1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // Spec rule: clamp magnitude, scale, add/subtract.
  function automatic int exp_width(logic [31:0] x);
    longint mag, off;
    mag = longint'(x[30:0]);
    if (mag > longint'(MD) * 65536)
      mag = longint'(MD) * 65536;
    off = (mag * K) / 65536;
    return x[31] ? C - int'(off) : C + int'(off);
  endfunction

  typedef struct {
    time t;
    int  ch;
    int  w;
  } st_t;

  st_t    sq[$];
  int     msh [2][NC];
  int     mac [2][NC];
  bit     mpd [2][NC];
  int     ecnt;
  int     wcnt[2][NC];
  int     wexp[2][NC];
  int     wlen;
  bit     wval, taint;
  int     mw[2][NC];

  // Model (edge just past) then per-period width checker.
  always @(negedge clk) begin
    if (rst) begin
      ecnt = 0;
      sq.delete();
      wval = 0;
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NC; c++) begin
          msh[d][c] = C;
          mac[d][c] = C;
          mpd[d][c] = 0;
        end
    end else begin
      if (ecnt % P == P - 1) begin
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < NC; c++)
            if (mpd[d][c]) begin
              int dl, s;
              s  = d ? S1 : 0;
              dl = msh[d][c] - mac[d][c];
              if (s != 0 && dl > s) dl = s;
              if (s != 0 && dl < -s) dl = -s;
              mac[d][c] += dl;
              mpd[d][c] = (mac[d][c] != msh[d][c]);
            end
      end
      while (sq.size() > 0 && sq[0].t == $time - 5) begin
        st_t s;
        s = sq.pop_front();
        if (s.ch < NC)
          for (int d = 0; d < 2; d++) begin
            msh[d][s.ch] = s.w;
            mpd[d][s.ch] = 1;
          end
      end
      ecnt++;
      if (ps0) begin
        if (wval && !taint) begin
          chk("period_len", wlen, P);
          for (int d = 0; d < 2; d++)
            for (int c = 0; c < NC; c++)
              chk($sformatf("width_d%0d_ch%0d", d, c),
                  wcnt[d][c], wexp[d][c]);
        end
        wval  = 1;
        taint = 0;
        wlen  = 0;
        for (int d = 0; d < 2; d++)
          for (int c = 0; c < NC; c++) begin
            wcnt[d][c] = 0;
            wexp[d][c] = mac[d][c];
          end
      end
      if (wval) begin
        wlen++;
        if (en != '1) taint = 1;
        for (int c = 0; c < NC; c++) begin
          wcnt[0][c] += int'(pwm0[c]);
          wcnt[1][c] += int'(pwm1[c]);
        end
      end
    end
  end

  // Drive one write to both DUTs; call at a negedge.
  task automatic wr(input int ch, input logic [31:0] x);
    int g = 0;
    while (!if0.wr_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!if0.wr_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    if0.wr_valid = 1'b1;
    if1.wr_valid = 1'b1;
    if0.wr_ch    = 4'(ch);
    if1.wr_ch    = 4'(ch);
    if0.wr_xita  = x;
    if1.wr_xita  = x;
    sq.push_back('{$time + 25, ch, exp_width(x)});
    @(negedge clk);
    if0.wr_valid = 1'b0;
    if1.wr_valid = 1'b0;
  endtask

  task automatic wait_ps();
    int g = 0;
    while (ps0 !== 1'b1 && g < 2 * P + 10) begin
      @(negedge clk);
      g++;
    end
    if (ps0 !== 1'b1) chk("ps_timeout", 0, 1);
  endtask

  task automatic measure();
    wait_ps();
    for (int c = 0; c < NC; c++) begin
      mw[0][c] = 0;
      mw[1][c] = 0;
    end
    for (int k = 0; k < P; k++) begin
      for (int c = 0; c < NC; c++) begin
        mw[0][c] += int'(pwm0[c]);
        mw[1][c] += int'(pwm1[c]);
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] x;
    int          w;
  } vec_t;

  vec_t tbl[6];
  int   slew_exp[6];

  initial begin
    tbl[0] = '{32'h002D_0000, 290};
    tbl[1] = '{32'h805A_0000, 20};
    tbl[2] = '{32'h0060_0000, 380};
    tbl[3] = '{32'h8064_0000, 20};
    tbl[4] = '{32'h8000_0000, 200};
    tbl[5] = '{32'h0000_8000, 201};
    slew_exp = '{240, 280, 320, 360, 380, 380};
    en = '1;
    if0.wr_valid = 1'b0;
    if1.wr_valid = 1'b0;
    if0.wr_ch = '0;
    if1.wr_ch = '0;
    if0.wr_xita = '0;
    if1.wr_xita = '0;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready0", int'(if0.wr_ready), 1);
    chk("rst_ready1", int'(if1.wr_ready), 1);
    chk("rst_pwm0", int'(pwm0), 0);
    chk("rst_pwm1", int'(pwm1), 0);
    chk("rst_ps", int'(ps0), 0);
    chk("rst_err", int'(if0.wr_err), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    measure();
    for (int c = 0; c < NC; c++)
      chk($sformatf("idle_w_ch%0d", c), mw[0][c], C);
    measure();

    // Handshake timing and first widths.
    wait_ps();
    wr(0, 32'h002D_0000);
    chk("hs_ready_t1", int'(if0.wr_ready), 0);
    @(negedge clk);
    chk("hs_ready_t2", int'(if0.wr_ready), 0);
    @(negedge clk);
    chk("hs_ready_t3", int'(if0.wr_ready), 1);
    chk("hs_err", int'(if0.wr_err), 0);
    wr(1, 32'h805A_0000);
    measure();
    chk("w45", mw[0][0], 290);
    chk("wm90", mw[0][1], 20);

    for (int i = 0; i < 6; i++) begin
      wait_ps();
      wr(i % NC, tbl[i].x);
      measure();
      chk($sformatf("tbl%0d", i), mw[0][i % NC], tbl[i].w);
    end

    // Slew: settle ch2 at center, then step to +90.
    wait_ps();
    wr(2, 32'h0000_0000);
    repeat (7) measure();
    chk("slew_base", mw[1][2], C);
    wait_ps();
    wr(2, 32'h005A_0000);
    for (int k = 0; k < 6; k++) begin
      measure();
      chk($sformatf("slew_d1_p%0d", k), mw[1][2],
          slew_exp[k]);
      chk($sformatf("slew_d0_p%0d", k), mw[0][2], 380);
    end

    // Store lands on the boundary edge itself.
    begin
      int g = 0;
      while (!((ecnt % P == P - 3) && if0.wr_ready)
             && g < 2 * P) begin
        @(negedge clk);
        g++;
      end
    end
    wr(3, 32'h0014_0000);
    measure();
    chk("coin_old_d0", mw[0][3], 20);
    chk("coin_old_d1", mw[1][3], 20);
    measure();
    chk("coin_new_d0", mw[0][3], 240);
    chk("coin_new_d1", mw[1][3], 60);

    // Out-of-range channel.
    wait_ps();
    wr(NC, 32'h002D_0000);
    chk("bad_ready_t1", int'(if0.wr_ready), 0);
    chk("bad_err_t1", int'(if0.wr_err), 0);
    @(negedge clk);
    chk("bad_err_t2", int'(if0.wr_err), 0);
    @(negedge clk);
    chk("bad_err_t3", int'(if0.wr_err), 1);
    @(negedge clk);
    chk("bad_err_t4", int'(if0.wr_err), 0);
    measure();
    chk("bad_nochg", mw[0][0], 200);

    // Back-to-back writes: last wins.
    wait_ps();
    wr(1, 32'h000A_0000);
    wr(1, 32'h801E_0000);
    measure();
    chk("b2b_last", mw[0][1], 140);

    // Enable dropped mid-pulse.
    wait_ps();
    repeat (3) @(negedge clk);
    chk("en_pre", int'(pwm0[0]), 1);
    en[0] = 1'b0;
    @(negedge clk);
    chk("en_drop0", int'(pwm0[0]), 0);
    chk("en_drop1", int'(pwm1[0]), 0);
    chk("en_other", int'(pwm0[1]), 1);
    en = '1;
    measure();
    measure();
    chk("en_keep", mw[0][0], 200);

    // Reset mid-pulse.
    wait_ps();
    wr(0, 32'h002D_0000);
    measure();
    chk("pre_rst_w", mw[0][0], 290);
    wait_ps();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_pwm0", int'(pwm0), 0);
    chk("mid_rst_pwm1", int'(pwm1), 0);
    chk("mid_rst_ready", int'(if0.wr_ready), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    measure();
    chk("post_rst_d0", mw[0][0], C);
    chk("post_rst_d1", mw[1][0], C);
    chk("post_rst_ch1", mw[0][1], C);

    // Reset while converter is in MUL.
    wr(1, 32'h005A_0000);
    #2 rst = 1'b1;
    #1;
    chk("mul_rst_ready", int'(if0.wr_ready), 1);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    measure();
    measure();
    chk("mul_rst_lost", mw[0][1], C);

    // Random writes, checked by the period model.
    for (int n = 0; n < 40; n++) begin
      int gap;
      logic [31:0] x;
      gap = ($urandom_range(0, 3) == 0)
          ? 0 : int'($urandom_range(1, 150));
      repeat (gap) @(negedge clk);
      x = {1'($urandom_range(0, 1)),
           15'($urandom_range(0, 100)),
           16'($urandom)};
      wr(int'($urandom_range(0, NC)), x);
    end
    repeat (8) measure();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
